// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults and counter-width helper for the debounce_sync block.
//
// Contents:
//   cnt_width(n)  - bits needed to hold the values 0..n (never less than 1)
//   Def*          - default parameter values used by debounce_sync and debounce_ch
package debounce_pkg;

    localparam int unsigned DefChannels       = 4;
    localparam int unsigned DefSyncStages     = 2;
    localparam int unsigned DefDebounceCycles = 16;
    localparam int unsigned DefRstCh          = 0;
    localparam int unsigned DefRstHold        = 8;
    localparam int unsigned DefLongCycles     = 1024;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Counter widths for the default configuration.
    localparam int unsigned DefDebounceCntW = cnt_width(DefDebounceCycles);
    localparam int unsigned DefHoldCntW     = cnt_width(DefRstHold);
    localparam int unsigned DefLongCntW     = cnt_width(DefLongCycles);

endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one input channel of debounce_sync.
//
// Synchronises a raw pin, debounces it with a mismatch counter, and emits registered
// one-cycle press/release pulses in the first cycle the new level is visible.
// Optional long-press detector enabled by the macro DEBOUNCE_LONG_PRESS_EN; when the
// macro is undefined long_o is tied low and no long-press counter exists.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   raw_i      raw asynchronous pin level
//   level_o    debounced level, 1 = pressed
//   press_o    one-cycle pulse on debounced 0->1
//   release_o  one-cycle pulse on debounced 1->0
//   long_o     one-cycle pulse LONG_CYCLES cycles after press_o (optional feature)
module debounce_ch import debounce_pkg::*; #(
    parameter int unsigned SYNC_STAGES     = DefSyncStages,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter logic        ACTIVE_LOW      = 1'b1,
    parameter int unsigned LONG_CYCLES     = DefLongCycles
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_params
        $error("debounce_ch: illegal parameter set");
    end

    localparam int unsigned     CntW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pressed;
    logic [CntW-1:0]        cnt_d, cnt_q;
    logic                   level_d, level_q;
    logic                   press_d, press_q;
    logic                   release_d, release_q;

    // Synchroniser resets to the released pin level so leaving reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    always_comb begin
        pressed   = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
        level_d   = level_q;
        cnt_d     = '0;
        if (pressed != level_q) begin
            // Flip only after DEBOUNCE_CYCLES consecutive mismatching samples.
            if (cnt_q == CntMax) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned      LongW    = cnt_width(LONG_CYCLES);
    localparam logic [LongW-1:0] LongMax  = LongW'(LONG_CYCLES);
    localparam logic [LongW-1:0] LongFire = LongW'(LONG_CYCLES - 1);

    logic [LongW-1:0] long_cnt_d, long_cnt_q;
    logic             long_d, long_q;

    // Counts cycles since the level rose; saturating at LongMax allows one pulse per press.
    always_comb begin
        long_cnt_d = long_cnt_q;
        long_d     = 1'b0;
        if (!level_q) begin
            long_cnt_d = '0;
        end else if (long_cnt_q != LongMax) begin
            long_cnt_d = long_cnt_q + LongW'(1);
            long_d     = (long_cnt_q == LongFire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            long_cnt_q <= long_cnt_d;
            long_q     <= long_d;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_sync.sv
// debounce_sync: multi-channel pin conditioner and system-reset generator.
//
// Each of CHANNELS pins goes through a debounce_ch (synchroniser, debounce counter,
// press/release pulses, optional long-press pulse). The debounced level of channel
// RST_CH additionally drives rst_out_n, which asserts asynchronously with rst_n and
// releases synchronously RST_HOLD cycles after every reset cause has ended.
// Optional feature macro: DEBOUNCE_LONG_PRESS_EN (long_o pulses; otherwise long_o = 0).
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   raw_i      raw asynchronous pin levels [CHANNELS]
//   level_o    debounced levels, 1 = pressed [CHANNELS]
//   press_o    one-cycle pulses on debounced 0->1 [CHANNELS]
//   release_o  one-cycle pulses on debounced 1->0 [CHANNELS]
//   long_o     one-cycle long-press pulses [CHANNELS]
//   rst_out_n  system reset, active low
module debounce_sync import debounce_pkg::*; #(
    parameter int unsigned         CHANNELS        = DefChannels,
    parameter int unsigned         SYNC_STAGES     = DefSyncStages,
    parameter int unsigned         DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter logic [CHANNELS-1:0] ACTIVE_LOW      = {CHANNELS{1'b1}},
    parameter int unsigned         RST_CH          = DefRstCh,
    parameter int unsigned         RST_HOLD        = DefRstHold,
    parameter int unsigned         LONG_CYCLES     = DefLongCycles
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] raw_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] release_o,
    output logic [CHANNELS-1:0] long_o,
    output logic                rst_out_n
);

    if (CHANNELS < 1 || RST_HOLD < 1 || RST_CH >= CHANNELS) begin : g_bad_params
        $error("debounce_sync: illegal parameter set");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW[i]),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .raw_i     (raw_i[i]),
            .level_o   (level_o[i]),
            .press_o   (press_o[i]),
            .release_o (release_o[i]),
            .long_o    (long_o[i])
        );
    end

    localparam int unsigned      HoldW    = cnt_width(RST_HOLD);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_HOLD - 1);

    logic [HoldW-1:0] hold_d, hold_q;
    logic             rst_out_d, rst_out_q;
    logic             rst_src;

    assign rst_src = level_o[RST_CH];

    // A held reset button keeps the hold counter at zero; any new press restarts the hold.
    always_comb begin
        hold_d    = hold_q;
        rst_out_d = rst_out_q;
        if (rst_src) begin
            hold_d    = '0;
            rst_out_d = 1'b0;
        end else if (hold_q == HoldLast) begin
            rst_out_d = 1'b1;
        end else begin
            hold_d = hold_q + HoldW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            rst_out_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            rst_out_q <= rst_out_d;
        end
    end

    assign rst_out_n = rst_out_q;

endmodule
